// File: rtl/lanceur_ctrl_pkg.sv
// Shared definitions for the dice-roller controller: state encoding, die face table and
// display codes used by the downstream seven-segment translator.
package lanceur_ctrl_pkg;

    typedef enum logic [1:0] {
        StChoix  = 2'd0,
        StLance  = 2'd1,
        StResult = 2'd2
    } etat_t;

    localparam int unsigned NbFaces   = 8;
    localparam int unsigned CntWidth  = 7;
    localparam int unsigned PrescBits = 20;

    // Entry 0 sits in the least significant slot.
    localparam logic [NbFaces-1:0][CntWidth-1:0] FaceTable = {
        7'd100, 7'd30, 7'd20, 7'd12, 7'd10, 7'd8, 7'd6, 7'd4
    };

    localparam logic [2:0] FaceIdxReset = 3'd1;

    localparam logic [3:0] DispCodeZero  = 4'd10;
    localparam logic [3:0] DispCodeD     = 4'd11;
    localparam logic [3:0] DispCodeBlank = 4'd12;

    function automatic logic [CntWidth-1:0] face_value(input logic [2:0] idx);
        return FaceTable[idx];
    endfunction

endpackage

// File: rtl/detect_front.sv
// Edge detector for a synchronous, debounced button level. The previous value resets to 1 so
// a button held through reset does not look like a fresh press.
module detect_front (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rising,
    output logic falling
);

    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= sig;
        end
    end

    assign rising  = sig & ~prev_q;
    assign falling = ~sig & prev_q;

endmodule

// File: rtl/lanceur_ctrl.sv
// Dice-roller controller: face selection, animated roll while the roll button is held,
// and result latching on release. All outputs come straight from registers.
module lanceur_ctrl
    import lanceur_ctrl_pkg::*;
#(
    parameter int unsigned PRESC = 250000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BP_Sel,
    input  logic       BP_Lance,
    output logic [6:0] NB_Face,
    output logic [6:0] Resultat,
    output logic       Aff_Mode,
    output logic       Roulement
);

    localparam logic [PrescBits-1:0] PrescLast = PrescBits'(PRESC - 1);

    logic sel_rise;
    logic unused_sel_fall;
    logic lance_rise;
    logic lance_fall;

    detect_front u_front_sel (
        .clk     (CLK),
        .rst     (RST),
        .sig     (BP_Sel),
        .rising  (sel_rise),
        .falling (unused_sel_fall)
    );

    detect_front u_front_lance (
        .clk     (CLK),
        .rst     (RST),
        .sig     (BP_Lance),
        .rising  (lance_rise),
        .falling (lance_fall)
    );

    etat_t                 state_q;
    logic [2:0]            face_idx_q;
    logic [CntWidth-1:0]   nb_face_q;
    logic [CntWidth-1:0]   resultat_q;
    logic [CntWidth-1:0]   cnt_q;
    logic [PrescBits-1:0]  presc_q;
    logic                  aff_mode_q;
    logic                  roulement_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StChoix;
            face_idx_q  <= FaceIdxReset;
            nb_face_q   <= face_value(FaceIdxReset);
            resultat_q  <= '0;
            cnt_q       <= 7'd1;
            presc_q     <= '0;
            aff_mode_q  <= 1'b0;
            roulement_q <= 1'b0;
        end else begin
            unique case (state_q)
                StChoix: begin
                    // A roll request beats a simultaneous face change.
                    if (lance_rise) begin
                        state_q     <= StLance;
                        cnt_q       <= 7'd1;
                        presc_q     <= '0;
                        resultat_q  <= 7'd1;
                        aff_mode_q  <= 1'b1;
                        roulement_q <= 1'b1;
                    end else if (sel_rise) begin
                        face_idx_q <= face_idx_q + 3'd1;
                        nb_face_q  <= face_value(face_idx_q + 3'd1);
                    end
                end

                StLance: begin
                    if (lance_fall) begin
                        resultat_q  <= cnt_q;
                        state_q     <= StResult;
                        roulement_q <= 1'b0;
                    end else if (presc_q == PrescLast) begin
                        presc_q    <= '0;
                        resultat_q <= cnt_q;
                    end else begin
                        presc_q <= presc_q + 1'b1;
                    end
                    cnt_q <= (cnt_q >= nb_face_q) ? 7'd1 : cnt_q + 7'd1;
                end

                StResult: begin
                    if (lance_rise) begin
                        state_q     <= StLance;
                        cnt_q       <= 7'd1;
                        presc_q     <= '0;
                        resultat_q  <= 7'd1;
                        aff_mode_q  <= 1'b1;
                        roulement_q <= 1'b1;
                    end else if (sel_rise) begin
                        state_q    <= StChoix;
                        resultat_q <= '0;
                        aff_mode_q <= 1'b0;
                    end
                end

                default: begin
                    state_q     <= StChoix;
                    roulement_q <= 1'b0;
                    aff_mode_q  <= 1'b0;
                    resultat_q  <= '0;
                end
            endcase
        end
    end

    assign NB_Face   = nb_face_q;
    assign Resultat  = resultat_q;
    assign Aff_Mode  = aff_mode_q;
    assign Roulement = roulement_q;

endmodule
